adc_serial_responder: RTL and testbench
=======================================

ADC_SERIAL_RESPONDER -- requirements
Module: adc_serial_responder

Interface
REQ-001 Parameter DATA_W, default 12: sample width in bits.
REQ-002 Parameter LEAD_ZEROS, default 4: leading zero bits shifted out before the sample MSB.
REQ-003 Parameter SYNC_STAGES, default 2: flip-flop stages on each asynchronous input; legal range 2..3.
REQ-004 clk  input  1: single block clock; all state updates on rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 adc_clk  input  1: serial clock from the ADC reader; asynchronous to clk.
REQ-007 adc_cs  input  1: active-low chip select from the ADC reader; asynchronous to clk.
REQ-008 adc_sd  output  1: serial data to the reader, registered.
REQ-009 sample  input  DATA_W: next conversion value, qualified by sample_valid.
REQ-010 sample_valid  input  1: one-cycle strobe; loads sample into the hold register.
REQ-011 busy  output  1: high while a frame is in progress (states SHIFT and TAIL).
REQ-012 frame_done  output  1: one-cycle pulse when a complete frame finishes.
REQ-013 frame_abort  output  1: one-cycle pulse when adc_cs deasserts mid-frame.
REQ-014 frame_count  output  16: number of completed frames; wraps from 0xFFFF to 0x0000.

Function
REQ-015 adc_clk and adc_cs SHALL each pass through SYNC_STAGES flops; one further registered copy of each SHALL be kept for edge detection.
REQ-016 Frame length SHALL be N = LEAD_ZEROS + DATA_W bits (16 at defaults); frame word = LEAD_ZEROS zeros followed by hold register, MSB first.
REQ-017 The hold register SHALL load sample on every cycle sample_valid is high, regardless of state; its reset value is 0.
REQ-018 States SHALL be IDLE, SHIFT, TAIL.
REQ-019 IDLE: adc_sd = 0; on synced adc_cs falling edge -> SHIFT, load shift register with frame word, bit counter = 0, adc_sd = frame bit N-1 on the next cycle.
REQ-020 If sample_valid and the cs falling edge occur in the same cycle, the new sample SHALL be used in the frame (bypass).
REQ-021 SHIFT: on each synced adc_clk falling edge, counter increments and adc_sd presents the next lower frame bit; after the (N-1)th falling edge adc_sd holds bit 0.
REQ-022 SHIFT: the Nth falling edge -> TAIL, adc_sd = 0, frame_done pulses, frame_count increments.
REQ-023 TAIL: adc_sd = 0; further adc_clk edges ignored; synced adc_cs rising edge -> IDLE.
REQ-024 SHIFT: synced adc_cs rising edge -> IDLE, adc_sd = 0, frame_abort pulses, frame_count unchanged; cs rising takes priority over a same-cycle adc_clk falling edge.
REQ-025 adc_clk rising edges SHALL never change adc_sd; the reader samples on rising edges.
REQ-026 adc_sd SHALL change no later than SYNC_STAGES+2 clk cycles after the external adc_clk falling edge; correct operation requires adc_clk high and low phases of at least SYNC_STAGES+3 clk cycles each.
REQ-027 adc_clk edges while in IDLE SHALL be ignored.

Reset
REQ-028 While reset is high: state = IDLE, adc_sd = 0, busy = 0, frame_done = 0, frame_abort = 0, frame_count = 0, hold register = 0, shift register and bit counter = 0, synchronizer and edge flops = 1 (idle-high levels).
REQ-029 Reset asserted mid-frame SHALL abort silently to IDLE without a frame_abort pulse; a frame starts only on a cs falling edge seen after reset release.

Verification
REQ-030 Load sample 0xA5C, drop cs, 16 adc_clk cycles at 10 clk/phase -> reader captures 0x0A5C on rising edges, one frame_done, frame_count = 1.
REQ-031 sample_valid with 0x3FF in the same cycle as the synced cs falling edge (hold previously 0x001) -> frame carries 0x03FF.
REQ-032 Raise cs after 7 adc_clk falling edges -> frame_abort one cycle, adc_sd = 0, busy = 0, frame_count unchanged; next full frame completes normally.
REQ-033 Send 4 extra adc_clk cycles after the 16th, before cs rises -> adc_sd stays 0, no second frame_done.
REQ-034 Preload frame_count to 0xFFFF via 65535 frames (or forced) then one frame -> frame_count = 0x0000.
REQ-035 Assert reset after 5 falling edges -> adc_sd = 0 and all outputs at reset values next cycle, no frame_abort; new frame after release returns the current hold value.

Source files
------------

// File: rtl/adc_serial_responder.sv
// Serial ADC emulator: shifts a zero-padded sample out on adc_sd, MSB first,
// one bit per falling edge of the reader's asynchronous adc_clk while adc_cs is low.
module adc_serial_responder #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned LEAD_ZEROS  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_clk,
  input  logic              adc_cs,
  output logic              adc_sd,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [15:0]       frame_count
);

  localparam int unsigned FRAME_W = LEAD_ZEROS + DATA_W;
  localparam int unsigned CNT_W   = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
  localparam int unsigned COUNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync;
  logic                   clk_q, cs_q;
  logic                   clk_s, cs_s;
  logic                   clk_fall, cs_fall, cs_rise;

  logic [DATA_W-1:0]  hold;
  logic [DATA_W-1:0]  hold_eff;
  logic [FRAME_W-1:0] frame_word;
  logic [FRAME_W-1:0] shift_q, shift_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;

  logic               sd_nxt, busy_nxt, done_nxt, abort_nxt;
  logic [COUNT_W-1:0] count_nxt;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign clk_fall = clk_q & ~clk_s;
  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;

  // Synchronizers plus edge-detect copies; reset to the idle-high level.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      cs_sync  <= '1;
      clk_q    <= 1'b1;
      cs_q     <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], adc_clk};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
      clk_q    <= clk_s;
      cs_q     <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
    end else if (sample_valid) begin
      hold <= sample;
    end
  end

  // A sample arriving in the frame-start cycle bypasses the hold register.
  assign hold_eff   = sample_valid ? sample : hold;
  assign frame_word = FRAME_W'(hold_eff);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cs_fall) state_nxt = SHIFT;
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
        end else if (clk_fall && (bit_cnt == LAST_BIT)) begin
          state_nxt = TAIL;
        end
      end
      TAIL:  if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-register MSB is always the bit currently on adc_sd while shifting.
  always_comb begin
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt;
    sd_nxt      = 1'b0;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;
    count_nxt   = frame_count;
    busy_nxt    = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (cs_fall) begin
          shift_nxt   = frame_word;
          bit_cnt_nxt = '0;
          sd_nxt      = frame_word[FRAME_W-1];
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort_nxt   = 1'b1;
          shift_nxt   = '0;
          bit_cnt_nxt = '0;
        end else if (clk_fall) begin
          if (bit_cnt == LAST_BIT) begin
            done_nxt    = 1'b1;
            count_nxt   = frame_count + COUNT_W'(1);
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
          end else begin
            shift_nxt   = shift_q << 1;
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            sd_nxt      = shift_q[FRAME_W-2];
          end
        end else begin
          sd_nxt = shift_q[FRAME_W-1];
        end
      end
      TAIL: begin
        sd_nxt = 1'b0;
      end
      default: begin
        sd_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt     <= '0;
      adc_sd      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frame_count <= '0;
    end else begin
      shift_q     <= shift_nxt;
      bit_cnt     <= bit_cnt_nxt;
      adc_sd      <= sd_nxt;
      busy        <= busy_nxt;
      frame_done  <= done_nxt;
      frame_abort <= abort_nxt;
      frame_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Bench for adc_serial_responder: a reader model drives adc_clk/adc_cs and captures adc_sd;
// expected frame events are queued and checked by a monitor on frame_done/frame_abort.
module tb_adc_serial_responder;

  localparam int unsigned DATA_W = 12;
  localparam int PH = 10;

  typedef struct packed {
    logic        is_abort;
    logic [15:0] word;
    logic [15:0] count;
  } ev_t;

  logic              clk;
  logic              reset;
  logic              adc_clk;
  logic              adc_cs;
  logic              adc_sd;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              busy;
  logic              frame_done;
  logic              frame_abort;
  logic [15:0]       frame_count;

  logic [15:0] cap;
  ev_t         q[$];
  int          total = 0;
  int          bad   = 0;

  adc_serial_responder #(
    .DATA_W(DATA_W),
    .LEAD_ZEROS(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .adc_clk(adc_clk),
    .adc_cs(adc_cs),
    .adc_sd(adc_sd),
    .sample(sample),
    .sample_valid(sample_valid),
    .busy(busy),
    .frame_done(frame_done),
    .frame_abort(frame_abort),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reader samples adc_sd on rising adc_clk edges.
  always @(posedge adc_clk) cap <= {cap[14:0], adc_sd};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done/abort pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (frame_done || frame_abort) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: done=%b abort=%b count=%h at %0t",
                 frame_done, frame_abort, frame_count, $time);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("event_kind", 32'(frame_abort), 32'(e.is_abort));
        chk("frame_count", 32'(frame_count), 32'(e.count));
        if (e.is_abort) begin
          chk("abort_sd", 32'(adc_sd), 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
        end else begin
          chk("frame_word", 32'(cap), 32'(e.word));
        end
      end
    end
  end

  task automatic push(input logic is_abort, input logic [15:0] word, input logic [15:0] count);
    ev_t e;
    e.is_abort = is_abort;
    e.word     = word;
    e.count    = count;
    q.push_back(e);
  endtask

  task automatic load(input logic [DATA_W-1:0] v);
    sample       = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic cs_low();
    adc_cs = 1'b0;
    repeat (PH) @(negedge clk);
  endtask

  task automatic cs_high();
    adc_cs = 1'b1;
    repeat (PH) @(negedge clk);
  endtask

  task automatic clk_cycle();
    adc_clk = 1'b1;
    repeat (PH) @(negedge clk);
    adc_clk = 1'b0;
    repeat (PH) @(negedge clk);
  endtask

  task automatic full_frame();
    cs_low();
    for (int i = 0; i < 16; i++) begin
      clk_cycle();
      if (i == 7) chk("busy_mid_frame", 32'(busy), 32'd1);
    end
    cs_high();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected events missing at %0t", q.size(), $time);
      q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sd"}, 32'(adc_sd), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_abort"}, 32'(frame_abort), 32'd0);
    chk({tag, "_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    bad++;
    $display("FAIL timeout: bench did not complete at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset        = 1'b1;
    adc_clk      = 1'b0;
    adc_cs       = 1'b1;
    sample       = '0;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame
    load(12'hA5C);
    push(1'b0, 16'h0A5C, 16'd1);
    full_frame();
    drain();

    // Sample strobe coincident with the synchronized cs falling edge
    load(12'h001);
    push(1'b0, 16'h03FF, 16'd2);
    adc_cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sample       = 12'h3FF;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (PH) @(negedge clk);
    for (int i = 0; i < 16; i++) clk_cycle();
    cs_high();
    drain();

    // cs deasserted after 7 falling edges, then a normal frame
    load(12'h555);
    push(1'b1, 16'h0000, 16'd2);
    cs_low();
    for (int i = 0; i < 7; i++) clk_cycle();
    cs_high();
    drain();
    chk("after_abort_busy", 32'(busy), 32'd0);
    push(1'b0, 16'h0555, 16'd3);
    full_frame();
    drain();

    // Extra adc_clk cycles after the last bit
    load(12'h0F0);
    push(1'b0, 16'h00F0, 16'd4);
    cs_low();
    for (int i = 0; i < 16; i++) clk_cycle();
    for (int i = 0; i < 4; i++) begin
      adc_clk = 1'b1;
      chk("tail_sd", 32'(adc_sd), 32'd0);
      repeat (PH) @(negedge clk);
      adc_clk = 1'b0;
      repeat (PH) @(negedge clk);
      chk("tail_busy", 32'(busy), 32'd1);
    end
    cs_high();
    drain();

    // frame_count wrap
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.frame_count;
    @(negedge clk);
    chk("count_preload", 32'(frame_count), 32'h0000FFFF);
    push(1'b0, 16'h00F0, 16'h0000);
    full_frame();
    drain();
    chk("count_wrapped", 32'(frame_count), 32'd0);

    // Reset in the middle of a frame
    load(12'h2AA);
    cs_low();
    for (int i = 0; i < 5; i++) clk_cycle();
    reset  = 1'b1;
    adc_cs = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    load(12'h7E1);
    push(1'b0, 16'h07E1, 16'd1);
    full_frame();
    drain();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
